// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmitter between two result sources. The ALU source
//   gives a 16-bit result, sent as two frames, low byte first. The register
//   file source gives an 8-bit read, sent as one frame. Each source has a
//   one-entry buffer. A round-robin arbiter picks between the two buffers.
//   A small FSM drives the transmitter and follows its Busy handshake, so
//   that exactly one frame is launched per byte.
//
// Ports
//   CLK, Reset        rising-edge clock, asynchronous active-high reset
//   ALU_out/valid     ALU result and its 1-cycle strobe
//   RF_RdData/Valid   register-file read data and its 1-cycle strobe
//   Cfg_parity_*      parity config, latched when a source is granted
//   Tx_busy           Busy from the UART transmitter
//   Tx_data/valid     byte and 1-cycle launch pulse to the transmitter
//   Tx_parity_*       parity config, held for the whole frame
//   Sched_busy        a buffer is full or a transfer is in progress
//   Overflow          sticky: a strobe arrived for a full buffer
//   Tx_err            sticky: Tx_busy never rose after a launch
//
// ALU_WIDTH must be 2*DATA_WIDTH.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int ALU_WIDTH    = 16,
  parameter int BUSY_TIMEOUT = 7
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [ALU_WIDTH-1:0]  ALU_out,
  input  logic                  ALU_valid,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdValid,
  input  logic                  Cfg_parity_en,
  input  logic                  Cfg_parity_typ,
  input  logic                  Tx_busy,
  output logic [DATA_WIDTH-1:0] Tx_data,
  output logic                  Tx_data_valid,
  output logic                  Tx_parity_en,
  output logic                  Tx_parity_typ,
  output logic                  Sched_busy,
  output logic                  Overflow,
  output logic                  Tx_err
);

  localparam int CNT_W = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;

  state_t                state, state_nxt;
  logic [ALU_WIDTH-1:0]  alu_buf;
  logic [DATA_WIDTH-1:0] rf_buf;
  logic                  alu_full, rf_full;
  logic                  alu_free, rf_free, alu_take, rf_take;
  logic                  grant_alu, grant_nxt;
  logic                  contested, contested_nxt;
  logic                  last_tie_alu, last_tie_nxt;
  logic                  byte_idx, byte_idx_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] tx_data_nxt;
  logic                  tx_vld_nxt, par_en_nxt, par_typ_nxt, err_nxt;
  logic                  pick_alu;

  // A buffer is released on the edge that launches its last byte.
  // A strobe arriving on that same edge therefore refills it.
  assign alu_take   = ALU_valid  & (~alu_full | alu_free);
  assign rf_take    = RF_RdValid & (~rf_full  | rf_free);
  assign Sched_busy = alu_full | rf_full | (state != IDLE);

  // Tie-break pointer: it remembers who won the last contested grant.
  // The other source wins the next tie.
  assign pick_alu = alu_full & (~rf_full | ~last_tie_alu);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_alu;
    contested_nxt = contested;
    last_tie_nxt = last_tie_alu;
    byte_idx_nxt = byte_idx;
    cnt_nxt      = cnt;
    tx_data_nxt  = Tx_data;
    tx_vld_nxt   = 1'b0;
    par_en_nxt   = Tx_parity_en;
    par_typ_nxt  = Tx_parity_typ;
    err_nxt      = Tx_err;
    alu_free     = 1'b0;
    rf_free      = 1'b0;
    unique case (state)
      IDLE: begin
        if ((alu_full | rf_full) & ~Tx_busy) begin
          grant_nxt     = pick_alu;
          contested_nxt = alu_full & rf_full;
          byte_idx_nxt  = 1'b0;
          tx_data_nxt   = pick_alu ? alu_buf[DATA_WIDTH-1:0] : rf_buf;
          rf_free       = ~pick_alu;
          tx_vld_nxt    = 1'b1;
          par_en_nxt    = Cfg_parity_en;
          par_typ_nxt   = Cfg_parity_typ;
          state_nxt     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (Tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (cnt == TIMEOUT_VAL) begin
          // Abandon the transfer. Only an ALU word still on its first byte
          // holds its buffer. Every other case freed the buffer at launch,
          // and it may already hold new data.
          err_nxt      = 1'b1;
          alu_free     = grant_alu & ~byte_idx;
          byte_idx_nxt = 1'b0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_LO: begin
        if (~Tx_busy) begin
          if (grant_alu & ~byte_idx) begin
            // Send the high byte at once, so RF cannot slip in between.
            byte_idx_nxt = 1'b1;
            tx_data_nxt  = alu_buf[ALU_WIDTH-1:DATA_WIDTH];
            tx_vld_nxt   = 1'b1;
            alu_free     = 1'b1;
            state_nxt    = LAUNCH;
          end else begin
            byte_idx_nxt = 1'b0;
            if (contested) last_tie_nxt = grant_alu;
            state_nxt    = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      alu_full      <= 1'b0;
      rf_full       <= 1'b0;
      grant_alu     <= 1'b0;
      contested     <= 1'b0;
      last_tie_alu  <= 1'b0;
      byte_idx      <= 1'b0;
      cnt           <= '0;
      Tx_data       <= '0;
      Tx_data_valid <= 1'b0;
      Tx_parity_en  <= 1'b0;
      Tx_parity_typ <= 1'b0;
      Overflow      <= 1'b0;
      Tx_err        <= 1'b0;
    end else begin
      state         <= state_nxt;
      alu_full      <= alu_take | (alu_full & ~alu_free);
      rf_full       <= rf_take  | (rf_full  & ~rf_free);
      grant_alu     <= grant_nxt;
      contested     <= contested_nxt;
      last_tie_alu  <= last_tie_nxt;
      byte_idx      <= byte_idx_nxt;
      cnt           <= cnt_nxt;
      Tx_data       <= tx_data_nxt;
      Tx_data_valid <= tx_vld_nxt;
      Tx_parity_en  <= par_en_nxt;
      Tx_parity_typ <= par_typ_nxt;
      Overflow      <= Overflow | (ALU_valid & alu_full & ~alu_free)
                                | (RF_RdValid & rf_full & ~rf_free);
      Tx_err        <= err_nxt;
    end
  end

  // Buffer contents: the full flags above qualify them, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (alu_take) alu_buf <= ALU_out;
    if (rf_take)  rf_buf  <= RF_RdData;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler.
// It contains a responsive UART model that raises Busy after each launch.
// It also has a frame monitor and a high-level reference model.
// The model predicts the order of frames and their parity settings.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int BT = 7;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic [AW-1:0] ALU_out = '0;
  logic          ALU_valid = 1'b0;
  logic [DW-1:0] RF_RdData = '0;
  logic          RF_RdValid = 1'b0;
  logic          Cfg_parity_en = 1'b0;
  logic          Cfg_parity_typ = 1'b0;
  logic          Tx_busy;
  logic [DW-1:0] Tx_data;
  logic          Tx_data_valid, Tx_parity_en, Tx_parity_typ;
  logic          Sched_busy, Overflow, Tx_err;

  logic force_busy = 1'b0;
  logic uart_busy  = 1'b0;
  logic uart_on    = 1'b1;
  logic busy_q     = 1'b0;
  assign Tx_busy = force_busy | uart_busy;

  int checks = 0;
  int failures = 0;
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] last_out = '0;
  bit tie_last_alu = 1'b0;
  int dly = 0;
  int len = 0;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .ALU_WIDTH(AW), .BUSY_TIMEOUT(BT)) dut (
    .CLK(CLK), .Reset(Reset), .ALU_out(ALU_out), .ALU_valid(ALU_valid),
    .RF_RdData(RF_RdData), .RF_RdValid(RF_RdValid),
    .Cfg_parity_en(Cfg_parity_en), .Cfg_parity_typ(Cfg_parity_typ),
    .Tx_busy(Tx_busy), .Tx_data(Tx_data), .Tx_data_valid(Tx_data_valid),
    .Tx_parity_en(Tx_parity_en), .Tx_parity_typ(Tx_parity_typ),
    .Sched_busy(Sched_busy), .Overflow(Overflow), .Tx_err(Tx_err)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Tx_busy as the DUT saw it on the last rising edge.
  initial forever begin
    @(posedge CLK);
    busy_q = Tx_busy;
  end

  // Frame monitor and UART responder.
  // Busy rises 0..2 cycles after a launch and stays high for 3..6 cycles.
  initial forever begin
    @(negedge CLK);
    if (Reset) begin
      last_out = '0;
    end else if (Tx_data_valid) begin
      obs_q.push_back({Tx_parity_en, Tx_parity_typ, Tx_data});
      checks++;
      if (busy_q !== 1'b0) begin
        failures++;
        $display("FAIL launch_while_busy: Tx_busy=%b at launch edge, required 0", busy_q);
      end
      last_out = {Tx_parity_en, Tx_parity_typ, Tx_data};
      if (uart_on) begin
        dly = $urandom_range(0, 2);
        len = $urandom_range(3, 6);
      end
    end else begin
      checks++;
      if ({Tx_parity_en, Tx_parity_typ, Tx_data} !== last_out) begin
        failures++;
        $display("FAIL hold_stable: frame outputs=%h, required %h",
                 {Tx_parity_en, Tx_parity_typ, Tx_data}, last_out);
      end
    end
    if (dly > 0) begin
      dly--;
      uart_busy = 1'b0;
    end else if (len > 0) begin
      len--;
      uart_busy = 1'b1;
    end else begin
      uart_busy = 1'b0;
    end
  end

  // Reference model: expected frames for strobes issued together while idle.
  function automatic void model_burst(bit has_alu, logic [15:0] a, bit has_rf,
                                      logic [7:0] r, bit pen, bit ptyp);
    bit alu_first;
    alu_first = has_alu && (!has_rf || !tie_last_alu);
    if (has_alu && has_rf) tie_last_alu = alu_first;
    if (alu_first) begin
      exp_q.push_back({pen, ptyp, a[7:0]});
      exp_q.push_back({pen, ptyp, a[15:8]});
      if (has_rf) exp_q.push_back({pen, ptyp, r});
    end else begin
      if (has_rf) exp_q.push_back({pen, ptyp, r});
      if (has_alu) begin
        exp_q.push_back({pen, ptyp, a[7:0]});
        exp_q.push_back({pen, ptyp, a[15:8]});
      end
    end
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    #2;
    Reset = 1'b1;
    ALU_valid = 1'b0;
    RF_RdValid = 1'b0;
    force_busy = 1'b0;
    uart_on = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #2;
    Reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    tie_last_alu = 1'b0;
  endtask

  task automatic strobe(bit has_alu, logic [15:0] a, bit has_rf, logic [7:0] r);
    @(negedge CLK);
    ALU_out = a;
    ALU_valid = has_alu;
    RF_RdData = r;
    RF_RdValid = has_rf;
    @(negedge CLK);
    ALU_valid = 1'b0;
    RF_RdValid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!Sched_busy && !Tx_busy && !Tx_data_valid) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if ({Tx_data, Tx_data_valid, Tx_parity_en, Tx_parity_typ, Sched_busy, Overflow, Tx_err} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0",
               {Tx_data, Tx_data_valid, Tx_parity_en, Tx_parity_typ, Sched_busy, Overflow, Tx_err});
    end
    #2;
    Reset = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({Tx_data_valid, Sched_busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: valid/busy=%b, required 00", {Tx_data_valid, Sched_busy});
    end
  endtask

  task automatic test_single_rf();
    bit ok;
    apply_reset();
    Cfg_parity_en = 1'b1;
    Cfg_parity_typ = 1'b0;
    @(negedge CLK);
    RF_RdData = 8'hA5;
    RF_RdValid = 1'b1;
    @(negedge CLK);
    RF_RdValid = 1'b0;
    checks++;
    if (Tx_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL t1_early: Tx_data_valid=%b one edge after strobe, required 0", Tx_data_valid);
    end
    @(negedge CLK);
    checks++;
    if ({Tx_data_valid, Tx_parity_en, Tx_parity_typ, Tx_data} !== {3'b110, 8'hA5}) begin
      failures++;
      $display("FAIL t1_launch: valid/pen/ptyp/data=%h, required %h",
               {Tx_data_valid, Tx_parity_en, Tx_parity_typ, Tx_data}, {3'b110, 8'hA5});
    end
    @(negedge CLK);
    checks++;
    if (Tx_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL t1_pulse_width: Tx_data_valid=%b, required 0", Tx_data_valid);
    end
    wait_idle(ok);
    checks++;
    if (!ok || obs_q.size() != 1) begin
      failures++;
      $display("FAIL t1_frames: idle=%0d frames=%0d, required idle=1 frames=1", ok, obs_q.size());
    end
  endtask

  task automatic test_alu_two_bytes();
    bit ok, seen;
    apply_reset();
    Cfg_parity_en = 1'b1;
    Cfg_parity_typ = 1'b1;
    model_burst(1'b1, 16'h3C81, 1'b0, 8'h00, 1'b1, 1'b1);
    strobe(1'b1, 16'h3C81, 1'b0, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (obs_q.size() >= 1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL t2_first_launch: no launch within 20 cycles, required one");
    end
    // A config change between the ALU bytes must not affect the high byte.
    Cfg_parity_en = 1'b0;
    Cfg_parity_typ = 1'b0;
    wait_idle(ok);
    model_burst(1'b0, 16'h0000, 1'b1, 8'h77, 1'b0, 1'b0);
    strobe(1'b0, 16'h0000, 1'b1, 8'h77);
    wait_idle(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t2_count: idle=%0d frames=%0d, required idle=1 frames=%0d", ok, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t2_frame%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    apply_reset();
    Cfg_parity_en = 1'b1;
    Cfg_parity_typ = 1'b0;
    for (int p = 0; p < 3; p++) begin
      model_burst(1'b1, 16'h1234, 1'b1, 8'h55, 1'b1, 1'b0);
      strobe(1'b1, 16'h1234, 1'b1, 8'h55);
      wait_idle(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL t3_idle%0d: scheduler not idle within bound, required idle", p);
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t3_count: frames=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t3_frame%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    apply_reset();
    Cfg_parity_en = 1'b0;
    Cfg_parity_typ = 1'b1;
    force_busy = 1'b1;
    strobe(1'b0, 16'h0000, 1'b1, 8'h11);
    repeat (3) @(negedge CLK);
    checks++;
    if ({obs_q.size() == 0, Sched_busy, Overflow} !== 3'b110) begin
      failures++;
      $display("FAIL t4_held: noframe/busy/ovf=%b, required 110", {obs_q.size() == 0, Sched_busy, Overflow});
    end
    strobe(1'b0, 16'h0000, 1'b1, 8'h22);
    checks++;
    if (Overflow !== 1'b1) begin
      failures++;
      $display("FAIL t4_overflow_set: Overflow=%b, required 1", Overflow);
    end
    // Release Busy and strobe on the launch edge: this strobe must be accepted.
    force_busy = 1'b0;
    RF_RdData = 8'h33;
    RF_RdValid = 1'b1;
    @(negedge CLK);
    RF_RdValid = 1'b0;
    exp_q.push_back({1'b0, 1'b1, 8'h11});
    exp_q.push_back({1'b0, 1'b1, 8'h33});
    wait_idle(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t4_count: idle=%0d frames=%0d, required idle=1 frames=%0d", ok, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t4_frame%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (Overflow !== 1'b1) begin
      failures++;
      $display("FAIL t4_overflow_sticky: Overflow=%b, required 1", Overflow);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    uart_on = 1'b0;
    @(negedge CLK);
    RF_RdData = 8'h5A;
    RF_RdValid = 1'b1;
    @(negedge CLK);
    RF_RdValid = 1'b0;
    repeat (BT + 2) @(negedge CLK);
    checks++;
    if ({Tx_err, Sched_busy} !== 2'b01) begin
      failures++;
      $display("FAIL t5_before: err/busy=%b, required 01", {Tx_err, Sched_busy});
    end
    @(negedge CLK);
    checks++;
    if ({Tx_err, Sched_busy} !== 2'b10) begin
      failures++;
      $display("FAIL t5_expired: err/busy=%b, required 10", {Tx_err, Sched_busy});
    end
    repeat (5) @(negedge CLK);
    checks++;
    if ({Tx_err, Sched_busy, obs_q.size() == 1} !== 3'b101) begin
      failures++;
      $display("FAIL t5_after: err/busy/oneframe=%b, required 101", {Tx_err, Sched_busy, obs_q.size() == 1});
    end
    uart_on = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    apply_reset();
    Cfg_parity_en = 1'b1;
    Cfg_parity_typ = 1'b0;
    strobe(1'b1, 16'hBEEF, 1'b0, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (obs_q.size() >= 1) seen = 1'b1;
    end
    force_busy = 1'b1;
    repeat (3) @(negedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({Tx_data, Tx_data_valid, Tx_parity_en, Tx_parity_typ, Sched_busy, Overflow, Tx_err} !== 14'h0) begin
      failures++;
      $display("FAIL t6_reset_outputs: got %h, required 0",
               {Tx_data, Tx_data_valid, Tx_parity_en, Tx_parity_typ, Sched_busy, Overflow, Tx_err});
    end
    @(negedge CLK);
    @(negedge CLK);
    #2;
    Reset = 1'b0;
    force_busy = 1'b0;
    repeat (20) @(negedge CLK);
    checks++;
    if (obs_q.size() != 1 || Sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL t6_after: frames=%0d busy=%b, required frames=1 busy=0", obs_q.size(), Sched_busy);
    end
    if (obs_q.size() >= 1) begin
      checks++;
      if (obs_q[0] !== {1'b1, 1'b0, 8'hEF}) begin
        failures++;
        $display("FAIL t6_frame0: got %h, required %h", obs_q[0], {1'b1, 1'b0, 8'hEF});
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int kind;
    logic [15:0] a;
    logic [7:0] r;
    bit pen, ptyp;
    apply_reset();
    for (int n = 0; n < 25; n++) begin
      kind = $urandom_range(1, 3);
      a = 16'($urandom);
      r = 8'($urandom);
      pen = 1'($urandom);
      ptyp = 1'($urandom);
      Cfg_parity_en = pen;
      Cfg_parity_typ = ptyp;
      model_burst(kind[0], a, kind[1], r, pen, ptyp);
      strobe(kind[0], a, kind[1], r);
      wait_idle(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand_idle%0d: scheduler not idle within bound, required idle", n);
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size() || Overflow !== 1'b0 || Tx_err !== 1'b0) begin
      failures++;
      $display("FAIL rand_count: frames=%0d ovf=%b err=%b, required frames=%0d ovf=0 err=0",
               obs_q.size(), Overflow, Tx_err, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_frame%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rf();
    test_alu_two_bytes();
    test_simultaneous();
    test_overflow();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
